// File: rtl/imem_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
// A fetch entry pairs an instruction word with the PC it was fetched from.
package imem_prefetch_buffer_pkg;

   localparam int unsigned WORD_W = 32;
   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'd0;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instr;
   } fetch_entry_t;

   localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/imem_prefetch_buffer_prefetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with a flush (clear) input.
// The head entry is presented combinationally from storage, zeroed when empty.
module imem_prefetch_buffer_prefetch_fifo
   import imem_prefetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         i_clear,
   input  logic                         i_push,
   input  fetch_entry_t                 i_push_data,
   input  logic                         i_pop,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_valid_c,
   output fetch_entry_t                 o_head_c
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [CNT_W-1:0]   r_count;

   logic w_valid;
   logic w_push;
   logic w_pop;

   // A clear discards same-cycle push and pop alike.
   assign w_valid = (r_count != '0);
   assign w_push  = i_push && !i_clear;
   assign w_pop   = i_pop && w_valid && !i_clear;

   always_ff @(posedge clock) begin
      if (reset || i_clear) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // Storage needs no reset: entries are only observed behind a nonzero count.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= ENTRY_W'(i_push_data);
      end
   end

   assign o_count   = r_count;
   assign o_valid_c = w_valid;
   assign o_head_c  = w_valid ? fetch_entry_t'(r_mem[r_rd_ptr]) : '0;

endmodule

// File: rtl/imem_prefetch_buffer.sv
// Instruction prefetch buffer: runs its own fetch PC against a synchronous
// instruction memory and queues {pc, instr} pairs for the fetch/decode stage.
module imem_prefetch_buffer
   import imem_prefetch_buffer_pkg::*;
#(
   parameter int unsigned       DEPTH    = 4,
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                         clock,
   input  logic                         reset,
   output logic [WORD_W-1:0]            mem_addr,
   input  logic [WORD_W-1:0]            mem_data,
   input  logic                         redirect,
   input  logic [WORD_W-1:0]            redirect_pc,
   output logic                         instr_valid,
   output logic [WORD_W-1:0]            instr,
   output logic [WORD_W-1:0]            instr_pc,
   input  logic                         instr_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam int unsigned OCC_W = CNT_W + 1;

   logic [WORD_W-1:0] r_fetch_pc;
   logic [WORD_W-1:0] r_inflight_pc;
   logic              r_inflight;

   logic              w_pop;
   logic              w_push;
   logic              w_issue;
   logic              w_head_valid;
   logic [OCC_W-1:0]  w_occupancy;
   logic [CNT_W-1:0]  w_count;
   fetch_entry_t      w_push_entry;
   fetch_entry_t      w_head;

   // Occupancy counts the slot reserved for the in-flight response, so the
   // queue can never overflow.
   assign w_pop       = w_head_valid && instr_ready;
   assign w_push      = r_inflight && !redirect;
   assign w_occupancy = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
   assign w_issue     = !redirect && (w_occupancy < OCC_W'(DEPTH));

   assign w_push_entry.pc    = r_inflight_pc;
   assign w_push_entry.instr = mem_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_fetch_pc    <= RESET_PC;
         r_inflight_pc <= '0;
         r_inflight    <= 1'b0;
      end else if (redirect) begin
         r_fetch_pc <= redirect_pc;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + WORD_W'(1);
         end
      end
   end

   imem_prefetch_buffer_prefetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .i_clear     (redirect),
      .i_push      (w_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_pop),
      .o_count     (w_count),
      .o_valid_c   (w_head_valid),
      .o_head_c    (w_head)
   );

   assign mem_addr    = r_fetch_pc;
   assign count       = w_count;
   assign instr_valid = w_head_valid;
   assign instr       = w_head.instr;
   assign instr_pc    = w_head.pc;

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Self-checking bench for imem_prefetch_buffer: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_imem_prefetch_buffer;

   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'd0;

   logic        clock       = 1'b0;
   logic        reset       = 1'b1;
   logic        redirect    = 1'b0;
   logic        instr_ready = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic [31:0] mem_data    = 32'd0;
   logic [31:0] mem_addr;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic [2:0]  count;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: delivered-order queue plus one pending fetch.
   logic [31:0] m_pc_q[$];
   logic [31:0] m_ins_q[$];
   logic [31:0] m_fetch_pc = 32'd0;
   logic        m_pend     = 1'b0;
   logic [31:0] m_pend_pc  = 32'd0;

   imem_prefetch_buffer #(
      .DEPTH    (DEPTH),
      .RESET_PC (RST_PC)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .count       (count)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Synchronous instruction memory: one-cycle read latency.
   always @(posedge clock) mem_data <= mem_word(mem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      chk("mem_addr", mem_addr, m_fetch_pc);
      chk("count", 32'(count), 32'(m_pc_q.size()));
      chk("instr_valid", 32'(instr_valid), 32'(m_pc_q.size() != 0));
      if (m_pc_q.size() != 0) begin
         chk("instr_pc", instr_pc, m_pc_q[0]);
         chk("instr", instr, m_ins_q[0]);
      end else begin
         chk("instr_pc_empty", instr_pc, 32'd0);
         chk("instr_empty", instr, 32'd0);
      end
   endtask

   task automatic model_step(input logic rst, input logic redir, input logic [31:0] rpc,
                             input logic rdy);
      logic pop;
      int   used;
      if (rst) begin
         m_pc_q.delete(); m_ins_q.delete();
         m_fetch_pc = RST_PC;
         m_pend     = 1'b0;
      end else if (redir) begin
         m_pc_q.delete(); m_ins_q.delete();
         m_fetch_pc = rpc;
         m_pend     = 1'b0;
      end else begin
         pop  = (m_pc_q.size() != 0) && rdy;
         used = m_pc_q.size() + int'(m_pend) - int'(pop);
         if (pop) begin
            void'(m_pc_q.pop_front());
            void'(m_ins_q.pop_front());
         end
         if (m_pend) begin
            m_pc_q.push_back(m_pend_pc);
            m_ins_q.push_back(mem_word(m_pend_pc));
         end
         if (used < DEPTH) begin
            m_pend_pc  = m_fetch_pc;
            m_fetch_pc = m_fetch_pc + 32'd1;
            m_pend     = 1'b1;
         end else begin
            m_pend = 1'b0;
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model, then check the next cycle.
   task automatic step(input logic rst, input logic redir, input logic [31:0] rpc,
                       input logic rdy);
      reset       = rst;
      redirect    = redir;
      redirect_pc = rpc;
      instr_ready = rdy;
      model_step(rst, redir, rpc, rdy);
      @(negedge clock);
      compare_model();
   endtask

   initial begin
      @(negedge clock);

      // Reset state and streaming with a ready consumer.
      step(1'b1, 1'b0, 32'd0, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'd0);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      chk("lat_n1_valid", 32'(instr_valid), 32'd0);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      chk("lat_n2_valid", 32'(instr_valid), 32'd1);
      chk("lat_n2_pc", instr_pc, 32'd0);
      chk("lat_n2_instr", instr, mem_word(32'd0));
      for (int k = 1; k <= 5; k++) begin
         step(1'b0, 1'b0, 32'd0, 1'b1);
         chk("stream_pc", instr_pc, 32'(k));
         chk("stream_count", 32'(count), 32'd1);
      end

      // Consumer stall fills the queue; release drains in order.
      step(1'b1, 1'b0, 32'd0, 1'b0);
      for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
      chk("stall_count", 32'(count), 32'd4);
      chk("stall_mem_addr", mem_addr, 32'd4);
      for (int k = 0; k <= 4; k++) begin
         chk("drain_pc", instr_pc, 32'(k));
         step(1'b0, 1'b0, 32'd0, 1'b1);
      end

      // Redirect with count=3 and a fetch in flight.
      step(1'b1, 1'b0, 32'd0, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
      chk("pre_redir_count", 32'(count), 32'd3);
      step(1'b0, 1'b1, 32'h40, 1'b0);
      chk("redir_valid", 32'(instr_valid), 32'd0);
      chk("redir_mem_addr", mem_addr, 32'h40);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      chk("redir_r2_valid", 32'(instr_valid), 32'd0);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      chk("redir_r3_pc", instr_pc, 32'h40);

      // Redirect with a same-cycle pop, then a second redirect.
      step(1'b0, 1'b1, 32'h100, 1'b1);
      step(1'b0, 1'b1, 32'h200, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      chk("dbl_redir_pc", instr_pc, 32'h200);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      chk("dbl_redir_pc_next", instr_pc, 32'h201);

      // Fetch PC wrap-around.
      step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      chk("wrap_pc0", instr_pc, 32'hFFFF_FFFE);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      chk("wrap_pc1", instr_pc, 32'hFFFF_FFFF);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      chk("wrap_pc2", instr_pc, 32'h0);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      chk("wrap_pc3", instr_pc, 32'h1);

      // Reset with a full queue.
      for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
      chk("full_count", 32'(count), 32'd4);
      step(1'b1, 1'b0, 32'd0, 1'b1);
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_valid", 32'(instr_valid), 32'd0);
      chk("midrst_mem_addr", mem_addr, RST_PC);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      chk("midrst_first_pc", instr_pc, 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic        r_rst;
         logic        r_redir;
         logic        r_rdy;
         logic [31:0] r_pc;
         r_rst   = ($urandom_range(0, 99) == 0);
         r_redir = ($urandom_range(0, 19) == 0);
         r_rdy   = ($urandom_range(0, 3) != 0);
         r_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                               : 32'($urandom);
         step(r_rst, r_redir, r_pc, r_rdy);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_prefetch_buffer.md
# imem_prefetch_buffer

Instruction prefetch buffer between the synchronous instruction memory and the processor's fetch/decode boundary. It runs its own fetch PC, keeps up to DEPTH fetched {pc, instruction} pairs queued, and presents them in order to the processor. On a taken branch or jump it discards all queued and in-flight fetches and restarts at the redirect target. With a continuously ready consumer it sustains one instruction per cycle.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 32'd0: first fetch address after reset.
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; reset wins over every other input.
- mem_addr  out  32  instruction memory word address; equals fetch_pc.
- mem_data  in  32  instruction memory output; valid in the cycle after mem_addr was sampled.
- redirect  in  1  taken-branch/jump flush from the execute stage.
- redirect_pc  in  32  restart address; sampled only when redirect=1.
- instr_valid  out  1  head entry present.
- instr  out  32  head instruction.
- instr_pc  out  32  head instruction's PC.
- instr_ready  in  1  consumer accepts the head (pop = instr_valid & instr_ready); the processor drives ~stall.
- count  out  $clog2(DEPTH+1)  queued entries.

## Operation
- State: fetch_pc (32), inflight flag (1), queue of DEPTH {pc, instr} entries, rd/wr pointers, count.
- Issue: `issue = !redirect && (count + inflight - pop) < DEPTH`. On issue: `inflight_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 1` (mod 2^32), `inflight <= 1`. Otherwise `inflight <= 0`, and fetch_pc holds.
- Response: if inflight=1 and redirect=0, write `{inflight_pc, mem_data}` at wr_ptr and increment wr_ptr mod DEPTH.
- Pop: increment rd_ptr mod DEPTH. `count <= count + push - pop`.
- Redirect: `fetch_pc <= redirect_pc`, `count <= 0`, pointers reset, `inflight <= 0`. A response arriving in the same cycle is dropped. A pop in the same cycle is ignored, and the consumer treats the presented head as squashed.
- Outputs instr and instr_pc come combinationally from the registered head entry. When count=0, instr_valid=0 and instr/instr_pc are don't-care, with the RTL driving 0.
- Reset values: fetch_pc=RESET_PC, so mem_addr=RESET_PC. count=0, instr_valid=0, instr=0, instr_pc=0, inflight=0, pointers=0.

## Timing
- Fetch latency: an address issued in cycle t has its data on mem_data in cycle t+1, and the entry is visible (instr_valid=1) in cycle t+2. There is no same-cycle bypass.
- After reset deasserts (first cycle N): mem_addr=RESET_PC in N, first instr_valid in N+2.
- Redirect in cycle r: instr_valid=0 from r+1, mem_addr=redirect_pc in r+1, first new instruction valid in r+3. Penalty is 2 bubbles beyond the execute-stage flush.
- Steady state with instr_ready held at 1: count is 1 and one instruction is accepted per cycle.
- Full queue: with count=DEPTH and no pop, no issue occurs and mem_addr holds.
- Full queue, inflight=0, with a pop: issue occurs the same cycle.
- The queue can never overflow: the issue rule reserves a slot for every in-flight response.
- Consumer stall: instr_ready=0 holds the head stable. Filling continues until count=DEPTH.
- Reset mid-operation discards everything, and the next cycle matches the post-reset state.
- Wrap-around: fetch_pc 32'hFFFFFFFF increments to 0. Pointers wrap modulo DEPTH with no lost or duplicated entries.

## Structure
- Shared package holds WORD_W=32, RESET_PC default, and the {pc, instr} fetch-entry struct/width constant.
- Sub-module prefetch_fifo: DEPTH-entry synchronous FIFO with push/pop/clear, count, and head outputs.
- The top level holds fetch_pc, the inflight flag and the issue logic.

## Test plan
- Reset, then instr_ready=1, with mem holding word k at address k: instr_pc = 0,1,2,3… on consecutive cycles starting at N+2, and instr equals mem[instr_pc].
- instr_ready=0 for 10 cycles: count saturates at 4, mem_addr freezes at 4, and on release the order is 0..3 then 4 with none dropped or repeated.
- redirect=1 with redirect_pc=0x40 while count=3 and inflight=1: next cycle instr_valid=0, mem_addr=0x40, and the next valid has instr_pc=0x40 two cycles later.
- Redirect and pop in the same cycle, then redirect again in the next cycle: only the second target's instructions appear.
- redirect_pc=32'hFFFFFFFE: delivered PCs are FFFFFFFE, FFFFFFFF, 0, 1.
- Assert reset mid-stream with the queue full: the next cycle has count=0, instr_valid=0, mem_addr=RESET_PC, and the fetch sequence restarts at 0.
